// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice.
package full_adder_pkg;

    // Default operand width: the classic single-bit full-adder cell.
    localparam int unsigned FA_WIDTH_DEFAULT = 1;

endpackage : full_adder_pkg

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full-adder cell.
//   a, b : addend bits
//   ci   : carry-in
//   s    : sum bit
//   co   : carry-out (majority of a, b, ci)
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder_cell

// File: rtl/full_adder.sv
// Registered ripple-carry adder built from full_adder_cell, one-cycle latency.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   in_valid  : A/B/Cin valid this cycle
//   A, B      : WIDTH-bit addends
//   Cin       : carry-in to bit 0
//   out_valid : Sum/Carry hold a fresh result
//   Sum       : registered (A+B+Cin) mod 2^WIDTH
//   Carry     : registered carry-out of the MSB
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = FA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    logic [WIDTH-1:0] sum_c;
    logic             carry_c;

    logic [WIDTH-1:0] sum_d,   sum_q;
    logic             carry_d, carry_q;
    logic             valid_d, valid_q;

    // Ripple chain: each bit takes its carry-in from the previous cell's carry-out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic ci_w;
        logic co_w;

        if (i == 0) begin : g_lsb
            assign ci_w = Cin;
        end else begin : g_rip
            assign ci_w = g_bit[i-1].co_w;
        end

        full_adder_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (ci_w),
            .s  (sum_c[i]),
            .co (co_w)
        );
    end

    assign carry_c = g_bit[WIDTH-1].co_w;

    // Capture a new result only when qualified; otherwise hold, so unqualified inputs never leak in.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = sum_c;
            carry_d = carry_c;
            valid_d = 1'b1;
        end
    end

    // Output registers; reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign Sum       = sum_q;
    assign Carry     = carry_q;
    assign out_valid = valid_q;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Self-checking bench: WIDTH=1 and WIDTH=8 instances against an arithmetic reference model.
module tb_full_adder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       Cin;
    logic       A1, B1;
    logic [7:0] A8, B8;

    logic       ov1, s1, c1;
    logic       ov8, c8;
    logic [7:0] s8;

    // Reference model state
    logic       m_v1, m_s1, m_c1;
    logic       m_v8, m_c8;
    logic [7:0] m_s8;

    int n_assert;
    int n_fail;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A1),
        .B         (B1),
        .Cin       (Cin),
        .out_valid (ov1),
        .Sum       (s1),
        .Carry     (c1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A8),
        .B         (B8),
        .Cin       (Cin),
        .out_valid (ov8),
        .Sum       (s8),
        .Carry     (c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one edge, update the model from the inputs seen at that edge, then check both DUTs.
    task automatic step();
        logic [1:0] t1;
        logic [8:0] t8;
        @(posedge clk);
        t1 = 2'(A1) + 2'(B1) + 2'(Cin);
        t8 = 9'(A8) + 9'(B8) + 9'(Cin);
        if (!rst_n) begin
            m_v1 = 1'b0; m_s1 = 1'b0; m_c1 = 1'b0;
            m_v8 = 1'b0; m_s8 = 8'h00; m_c8 = 1'b0;
        end else if (in_valid) begin
            m_v1 = 1'b1; m_s1 = t1[0]; m_c1 = t1[1];
            m_v8 = 1'b1; m_s8 = t8[7:0]; m_c8 = t8[8];
        end else begin
            m_v1 = 1'b0;
            m_v8 = 1'b0;
        end
        #1;
        chk("w1_valid", 32'(ov1), 32'(m_v1));
        chk("w1_sum",   32'(s1),  32'(m_s1));
        chk("w1_carry", 32'(c1),  32'(m_c1));
        chk("w8_valid", 32'(ov8), 32'(m_v8));
        chk("w8_sum",   32'(s8),  32'(m_s8));
        chk("w8_carry", 32'(c8),  32'(m_c8));
    endtask

    task automatic rand_inputs();
        A1  = 1'($urandom);
        B1  = 1'($urandom);
        A8  = 8'($urandom);
        B8  = 8'($urandom);
        Cin = 1'($urandom);
    endtask

    initial begin
        logic [1:0] tbl [8];
        logic [2:0] v;
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        n_assert = 0;
        n_fail   = 0;
        m_v1 = 1'b0; m_s1 = 1'b0; m_c1 = 1'b0;
        m_v8 = 1'b0; m_s8 = 8'h00; m_c8 = 1'b0;

        // Reset held two cycles with all-ones valid inputs
        rst_n = 1'b0; in_valid = 1'b1;
        A1 = 1'b1; B1 = 1'b1; Cin = 1'b1; A8 = 8'hFF; B8 = 8'hFF;
        step();
        step();
        chk("rst_sum",   32'(s1),  32'd0);
        chk("rst_carry", 32'(c1),  32'd0);
        chk("rst_valid", 32'(ov1), 32'd0);
        chk("rst_sum8",  32'(s8),  32'd0);

        // Release reset: 1+1+1 -> Sum=1, Carry=1
        #1 rst_n = 1'b1;
        step();
        chk("rel_sum",   32'(s1),  32'd1);
        chk("rel_carry", 32'(c1),  32'd1);
        chk("rel_valid", 32'(ov1), 32'd1);

        // Exhaustive single-bit truth table
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            A1 = v[2]; B1 = v[1]; Cin = v[0];
            A8 = 8'($urandom); B8 = 8'($urandom);
            step();
            chk("tt_carry_sum", 32'({c1, s1}), 32'(tbl[i]));
            chk("tt_valid",     32'(ov1),      32'd1);
        end

        // Hold: valid 1+0+0, then unqualified all-ones inputs
        A1 = 1'b1; B1 = 1'b0; Cin = 1'b0; A8 = 8'h10; B8 = 8'h20;
        step();
        in_valid = 1'b0;
        A1 = 1'b1; B1 = 1'b1; Cin = 1'b1; A8 = 8'hFF; B8 = 8'hFF;
        step();
        chk("hold_sum",   32'(s1),  32'd1);
        chk("hold_carry", 32'(c1),  32'd0);
        chk("hold_valid", 32'(ov1), 32'd0);
        chk("hold_sum8",  32'(s8),  32'h30);
        step();
        chk("hold2_sum8", 32'(s8),  32'h30);

        // 8-bit wrap-around corners
        in_valid = 1'b1;
        A8 = 8'hFF; B8 = 8'h01; Cin = 1'b0;
        step();
        chk("wrap1", 32'({c8, s8}), 32'h100);
        A8 = 8'hFF; B8 = 8'hFF; Cin = 1'b1;
        step();
        chk("wrap2", 32'({c8, s8}), 32'h1FF);
        A8 = 8'h12; B8 = 8'h34; Cin = 1'b1;
        step();
        chk("plain", 32'({c8, s8}), 32'h047);

        // Mid-stream reset for one cycle
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            step();
        end
        rand_inputs();
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 32'(ov8),      32'd0);
        chk("mid_rst_out",   32'({c8, s8}), 32'd0);
        rst_n = 1'b1;
        A8 = 8'h80; B8 = 8'h80; Cin = 1'b1;
        step();
        chk("resume", 32'({c8, s8}), 32'h101);
        chk("resume_valid", 32'(ov8), 32'd1);

        // Random stream with occasional idle cycles
        for (int i = 0; i < 1000; i++) begin
            rand_inputs();
            in_valid = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_full_adder

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder: adds operands A and B plus carry-in Cin, producing Sum and carry-out Carry.
- Default WIDTH=1 is the classic 1-bit full-adder cell; wider instances form a ripple-carry adder chained from that cell.
- Used as the basic arithmetic leaf in datapath blocks.
- Inputs are sampled with a valid qualifier; results are registered with one-cycle latency.

Parameters:
- WIDTH, 1, operand and sum width in bits (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  A/B/Cin are valid this cycle.
- A  input  WIDTH  addend.
- B  input  WIDTH  addend.
- Cin  input  1  carry-in to bit 0.
- out_valid  output  1  Sum/Carry hold a fresh result.
- Sum  output  WIDTH  registered (A+B+Cin) mod 2^WIDTH.
- Carry  output  1  registered carry-out of the MSB.

Behaviour:
- Reset: on a rising clk with rst_n=0, Sum=0, Carry=0, out_valid=0. Reset overrides in_valid in the same cycle.
- Per bit i, computed combinationally:
  - s_i = A_i ^ B_i ^ c_i
  - c_(i+1) = (A_i & B_i) | (A_i & c_i) | (B_i & c_i)
  - c_0 = Cin; Carry = c_WIDTH.
  - Result equals the low WIDTH bits plus bit WIDTH of the (WIDTH+1)-bit sum A+B+Cin.
- Latency: exactly 1 cycle.
  - If in_valid=1 at edge n (rst_n=1), Sum/Carry reflect those inputs after edge n and out_valid=1.
- in_valid=0 at an edge (rst_n=1): Sum/Carry hold previous values; out_valid=0.
- No backpressure: a new result may be accepted every cycle; back-to-back valid inputs produce back-to-back valid outputs.
- Overflow: wrap-around is not flagged separately; Carry=1 is the overflow indication for unsigned operands.
- No X propagation: unknown inputs with in_valid=0 must not alter the outputs.
- Reset asserted mid-stream: the pending result is discarded; out_valid=0 on the following cycle.
- No internal state beyond the output registers; no FSM.

Decomposition:
- Package full_adder_pkg: default WIDTH constant only; no typedefs required.
- Sub-module full_adder_cell: purely combinational 1-bit adder (a, b, ci -> s, co).
  - Instantiated WIDTH times in a generate loop with ripple carry.
- The top level owns the valid and output registers and the reset logic.

Test Plan:
- WIDTH=1 exhaustive: drive all 8 combinations (0,0,0)…(1,1,1) with in_valid=1, one per cycle.
  - Results one cycle later: Sum/Carry = 0/0, 1/0, 1/0, 0/1, 1/0, 0/1, 0/1, 1/1.
  - out_valid=1 throughout.
- Reset: hold rst_n=0 for 2 cycles with A=B=Cin=1, in_valid=1 -> Sum=0, Carry=0, out_valid=0.
  - Release reset -> next cycle Sum=1, Carry=1.
- Hold: apply A=1, B=0, Cin=0 valid (Sum=1), then in_valid=0 with A=B=Cin=1.
  - Sum=1, Carry=0 held; out_valid=0.
- WIDTH=8 wrap-around: A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Carry=1.
  - A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Carry=1.
  - A=0x12, B=0x34, Cin=1 -> Sum=0x47, Carry=0.
- Mid-stream reset: valid inputs every cycle, assert rst_n=0 for one cycle.
  - Outputs 0 and out_valid=0 the cycle after; stream resumes with 1-cycle latency.
- Random (WIDTH=8, 1000 vectors): {Carry,Sum} == A+B+Cin against a reference model, checked one cycle after each valid input.
